// File: rtl/sync_fifo_prog_if.sv
// Data/flag bundle between a FIFO client and sync_fifo_prog.
// Active-low names mirror the legacy FIFO part pinout.
interface sync_fifo_prog_if #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned PSIZE = 9
);
  logic [WIDTH-1:0] d;
  logic             wen_;
  logic             ren_;
  logic             ld_;
  logic [WIDTH-1:0] q;
  logic [PSIZE:0]   cnt;
  logic             ef_;
  logic             ff_;
  logic             hf_;
  logic             pae_;
  logic             paf_;
  logic             ovf;
  logic             udf;

  modport master (
    output d, wen_, ren_, ld_,
    input  q, cnt, ef_, ff_, hf_, pae_, paf_, ovf, udf
  );

  modport slave (
    input  d, wen_, ren_, ld_,
    output q, cnt, ef_, ff_, hf_, pae_, paf_, ovf, udf
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-empty/almost-full offsets,
// word count, sticky overflow/underflow and optional first-word-fall-through.
module sync_fifo_prog #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned PSIZE = 9,
  parameter bit          FWFT  = 1'b0
) (
  input logic              clk,
  input logic              rs,
  sync_fifo_prog_if.slave  bus
);
  localparam int unsigned MSIZE   = 1 << PSIZE;
  localparam int unsigned CW      = PSIZE + 1;
  localparam int unsigned HALF    = MSIZE / 2;
  localparam int unsigned OFF_RST = MSIZE / 8 - 1;

  logic [WIDTH-1:0] r_mem [MSIZE];
  logic [PSIZE-1:0] r_inptr;
  logic [PSIZE-1:0] r_outptr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [PSIZE-1:0] r_pae_off;
  logic [PSIZE-1:0] r_paf_off;
  logic             r_wsel;
  logic             r_rsel;
  logic             r_show_ld;
  logic             r_ef_;
  logic             r_ff_;
  logic             r_hf_;
  logic             r_pae_;
  logic             r_paf_;
  logic             r_ovf;
  logic             r_udf;

  logic             w_wr;
  logic             w_rd;
  logic             w_ldw;
  logic             w_ldr;
  logic [CW-1:0]    w_cnt_nxt;
  logic [PSIZE-1:0] w_pae_off_nxt;
  logic [PSIZE-1:0] w_paf_off_nxt;

  // Access decode; full/empty are the registered pre-edge flags.
  always_comb begin
    w_wr          = !bus.wen_ && bus.ld_ && r_ff_;
    w_rd          = !bus.ren_ && bus.ld_ && r_ef_;
    w_ldw         = !bus.wen_ && !bus.ld_;
    w_ldr         = !bus.ren_ && !bus.ld_;
    w_cnt_nxt     = r_cnt;
    w_pae_off_nxt = r_pae_off;
    w_paf_off_nxt = r_paf_off;
    if (w_wr && !w_rd) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (w_rd && !w_wr) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
    if (w_ldw) begin
      if (r_wsel) w_paf_off_nxt = bus.d[PSIZE-1:0];
      else        w_pae_off_nxt = bus.d[PSIZE-1:0];
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rs && w_wr) r_mem[r_inptr] <= bus.d;
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      r_inptr   <= '0;
      r_outptr  <= '0;
      r_cnt     <= '0;
      r_q       <= '0;
      r_pae_off <= PSIZE'(OFF_RST);
      r_paf_off <= PSIZE'(OFF_RST);
      r_wsel    <= 1'b0;
      r_rsel    <= 1'b0;
      r_show_ld <= 1'b0;
      r_ef_     <= 1'b0;
      r_ff_     <= 1'b1;
      r_hf_     <= 1'b1;
      r_pae_    <= 1'b0;
      r_paf_    <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_wr) r_inptr  <= r_inptr + PSIZE'(1);
      if (w_rd) r_outptr <= r_outptr + PSIZE'(1);
      r_cnt     <= w_cnt_nxt;
      r_pae_off <= w_pae_off_nxt;
      r_paf_off <= w_paf_off_nxt;
      r_wsel    <= bus.ld_ ? 1'b0 : (w_ldw ? !r_wsel : r_wsel);
      r_rsel    <= bus.ld_ ? 1'b0 : (w_ldr ? !r_rsel : r_rsel);
      // An offset readback holds q until array access resumes.
      r_show_ld <= bus.ld_ ? 1'b0 : (w_ldr ? 1'b1 : r_show_ld);
      if (w_ldr) begin
        r_q <= r_rsel ? WIDTH'(r_paf_off) : WIDTH'(r_pae_off);
      end else if (w_rd && !FWFT) begin
        r_q <= r_mem[r_outptr];
      end
      r_ef_  <= (w_cnt_nxt != '0);
      r_ff_  <= (w_cnt_nxt != CW'(MSIZE));
      r_hf_  <= !(w_cnt_nxt >= CW'(HALF));
      r_pae_ <= !(w_cnt_nxt <= CW'(w_pae_off_nxt));
      r_paf_ <= !((CW'(MSIZE) - w_cnt_nxt) <= CW'(w_paf_off_nxt));
      if (!bus.wen_ && bus.ld_ && !r_ff_) r_ovf <= 1'b1;
      if (!bus.ren_ && bus.ld_ && !r_ef_) r_udf <= 1'b1;
    end
  end

  assign bus.q    = (FWFT && r_ef_ && !r_show_ld) ? r_mem[r_outptr] : r_q;
  assign bus.cnt  = r_cnt;
  assign bus.ef_  = r_ef_;
  assign bus.ff_  = r_ff_;
  assign bus.hf_  = r_hf_;
  assign bus.pae_ = r_pae_;
  assign bus.paf_ = r_paf_;
  assign bus.ovf  = r_ovf;
  assign bus.udf  = r_udf;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: standard-read instance (a) and
// first-word-fall-through instance (b), both 8 deep x 18 bits.
module tb_sync_fifo_prog;
  localparam int unsigned WIDTH = 18;
  localparam int unsigned PSIZE = 3;

  logic clk = 1'b0;
  logic rs  = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  sync_fifo_prog_if #(.WIDTH(WIDTH), .PSIZE(PSIZE)) a ();
  sync_fifo_prog_if #(.WIDTH(WIDTH), .PSIZE(PSIZE)) b ();

  sync_fifo_prog #(.WIDTH(WIDTH), .PSIZE(PSIZE), .FWFT(1'b0)) u_a (
    .clk(clk), .rs(rs), .bus(a));
  sync_fifo_prog #(.WIDTH(WIDTH), .PSIZE(PSIZE), .FWFT(1'b1)) u_b (
    .clk(clk), .rs(rs), .bus(b));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rs = 1'b1;
    tick();
    rs = 1'b0;
  endtask

  task automatic wr_a(input logic [WIDTH-1:0] v);
    a.d = v; a.wen_ = 1'b0;
    tick();
    a.wen_ = 1'b1;
  endtask

  task automatic rd_a();
    a.ren_ = 1'b0;
    tick();
    a.ren_ = 1'b1;
  endtask

  task automatic wr_b(input logic [WIDTH-1:0] v);
    b.d = v; b.wen_ = 1'b0;
    tick();
    b.wen_ = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_pae;
    logic [7:0] exp_hf;
    logic [7:0] exp_paf;
    exp_pae = 8'b1111_1100;
    exp_hf  = 8'b0000_0111;
    exp_paf = 8'b0011_1111;

    a.d = '0; a.wen_ = 1'b1; a.ren_ = 1'b1; a.ld_ = 1'b1;
    b.d = '0; b.wen_ = 1'b1; b.ren_ = 1'b1; b.ld_ = 1'b1;
    tick();
    do_reset();

    // Reset state
    chk("rst_cnt",  32'(a.cnt),  32'd0);
    chk("rst_ef",   32'(a.ef_),  32'd0);
    chk("rst_pae",  32'(a.pae_), 32'd0);
    chk("rst_ff",   32'(a.ff_),  32'd1);
    chk("rst_hf",   32'(a.hf_),  32'd1);
    chk("rst_paf",  32'(a.paf_), 32'd1);
    chk("rst_ovf",  32'(a.ovf),  32'd0);
    chk("rst_udf",  32'(a.udf),  32'd0);
    chk("rst_q",    32'(a.q),    32'd0);

    // Fill 1..8, then overflow attempt
    for (int i = 1; i <= 8; i++) begin
      wr_a(WIDTH'(i));
      chk("fill_cnt", 32'(a.cnt), 32'(i));
    end
    chk("full_ff",  32'(a.ff_), 32'd0);
    chk("full_ovf_pre", 32'(a.ovf), 32'd0);
    wr_a(18'd9);
    chk("ovf_set",  32'(a.ovf), 32'd1);
    chk("ovf_cnt",  32'(a.cnt), 32'd8);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      rd_a();
      chk("drain_q", 32'(a.q), 32'(i));
    end
    chk("drain_ef",  32'(a.ef_), 32'd0);
    chk("drain_cnt", 32'(a.cnt), 32'd0);
    chk("drain_udf", 32'(a.udf), 32'd0);

    // Full plus read plus write: read wins, write dropped
    do_reset();
    for (int i = 0; i < 8; i++) wr_a(WIDTH'(10 + i));
    a.d = 18'd9; a.wen_ = 1'b0; a.ren_ = 1'b0;
    tick();
    a.wen_ = 1'b1; a.ren_ = 1'b1;
    chk("fullrw_q",   32'(a.q),   32'd10);
    chk("fullrw_cnt", 32'(a.cnt), 32'd7);
    chk("fullrw_ovf", 32'(a.ovf), 32'd1);
    for (int i = 1; i < 8; i++) begin
      rd_a();
      chk("fullrw_drain_q", 32'(a.q), 32'(10 + i));
    end
    chk("fullrw_empty", 32'(a.ef_), 32'd0);

    // Empty plus read plus write: write wins, udf set
    do_reset();
    a.d = 18'h33; a.wen_ = 1'b0; a.ren_ = 1'b0;
    tick();
    a.wen_ = 1'b1; a.ren_ = 1'b1;
    chk("emptyrw_cnt", 32'(a.cnt), 32'd1);
    chk("emptyrw_udf", 32'(a.udf), 32'd1);
    chk("emptyrw_ef",  32'(a.ef_), 32'd1);
    rd_a();
    chk("emptyrw_q",   32'(a.q),   32'h33);

    // Offset load and readback
    do_reset();
    a.ld_ = 1'b0; a.wen_ = 1'b0; a.d = 18'd2;
    tick();
    a.d = 18'd1;
    tick();
    a.wen_ = 1'b1; a.ren_ = 1'b0;
    tick();
    chk("ld_rd_pae", 32'(a.q), 32'd2);
    tick();
    chk("ld_rd_paf", 32'(a.q), 32'd1);
    a.ren_ = 1'b1; a.ld_ = 1'b1;
    chk("ld_cnt",  32'(a.cnt),  32'd0);
    chk("ld_pae0", 32'(a.pae_), 32'd0);
    chk("ld_paf0", 32'(a.paf_), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      wr_a(WIDTH'(c));
      chk("thr_pae", 32'(a.pae_), 32'(exp_pae[c-1]));
      chk("thr_hf",  32'(a.hf_),  32'(exp_hf[c-1]));
      chk("thr_paf", 32'(a.paf_), 32'(exp_paf[c-1]));
    end

    // Pointer wrap with steady occupancy of 3
    do_reset();
    wr_a(18'd100); wr_a(18'd101); wr_a(18'd102);
    for (int i = 0; i < 20; i++) begin
      a.d = WIDTH'(103 + i); a.wen_ = 1'b0; a.ren_ = 1'b0;
      tick();
      chk("wrap_q",   32'(a.q),   32'(100 + i));
      chk("wrap_cnt", 32'(a.cnt), 32'd3);
    end
    a.wen_ = 1'b1; a.ren_ = 1'b1;
    chk("wrap_ovf", 32'(a.ovf), 32'd0);
    chk("wrap_udf", 32'(a.udf), 32'd0);
    for (int i = 0; i < 3; i++) begin
      rd_a();
      chk("wrap_tail_q", 32'(a.q), 32'(120 + i));
    end

    // First-word-fall-through instance
    do_reset();
    wr_b(18'h155);
    chk("fwft_q",   32'(b.q),   32'h155);
    chk("fwft_ef",  32'(b.ef_), 32'd1);
    tick();
    chk("fwft_hold", 32'(b.q), 32'h155);
    wr_b(18'h2AA); wr_b(18'h0F0); wr_b(18'h00F); wr_b(18'h111);
    chk("fwft_cnt5", 32'(b.cnt), 32'd5);
    chk("fwft_head", 32'(b.q),   32'h155);
    b.ren_ = 1'b0;
    tick();
    b.ren_ = 1'b1;
    chk("fwft_pop_q",   32'(b.q),   32'h2AA);
    chk("fwft_pop_cnt", 32'(b.cnt), 32'd4);
    wr_b(18'h0AB);
    chk("fwft_refill", 32'(b.cnt), 32'd5);
    do_reset();
    chk("fwft_rs_cnt", 32'(b.cnt), 32'd0);
    chk("fwft_rs_ef",  32'(b.ef_), 32'd0);
    chk("fwft_rs_q",   32'(b.q),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
